// File: rtl/calendar_pkg.sv
// Shared calendar constants and the leap-year rule used by the date counter
// and its month-length lookup.
package calendar_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [4:0] LEN_31     = 5'd31;
    localparam logic [4:0] LEN_30     = 5'd30;
    localparam logic [4:0] FEB_NORMAL = 5'd28;
    localparam logic [4:0] FEB_LEAP   = 5'd29;

    localparam logic [2:0] SUN = 3'd0;
    localparam logic [2:0] MON = 3'd1;
    localparam logic [2:0] TUE = 3'd2;
    localparam logic [2:0] WED = 3'd3;
    localparam logic [2:0] THU = 3'd4;
    localparam logic [2:0] FRI = 3'd5;
    localparam logic [2:0] SAT = 3'd6;

    // Year is taken as a 32-bit unsigned value so the %100 / %400 tests stay
    // exact for every year a YEAR_W <= 32 register can hold.
    function automatic logic is_leap(input logic [31:0] year, input logic gregorian);
        logic div4;
        div4 = (year[1:0] == 2'b00);
        if (!gregorian)
            return div4;
        return ((year % 32'd400) == 32'd0) || (div4 && ((year % 32'd100) != 32'd0));
    endfunction

endpackage

// File: rtl/month_length_lut.sv
// Combinational month length for a (month, year) pair; 0 for an out-of-range month.
module month_length_lut
    import calendar_pkg::*;
#(
    parameter int YEAR_W    = 16,
    parameter bit GREGORIAN = 1'b1
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [4:0]        length
);

    logic leap;

    always_comb begin
        leap   = is_leap(32'(year), GREGORIAN);
        length = 5'd0;
        case (month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: length = LEN_31;
            APR, JUN, SEP, NOV:                length = LEN_30;
            FEB:                               length = leap ? FEB_LEAP : FEB_NORMAL;
            default:                           length = 5'd0;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year/weekday counter advanced by midnight ticks, with validated
// date loads and registered rollover pulses.
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W     = 16,
    parameter int YEAR_MIN   = 2000,
    parameter int YEAR_MAX   = 2199,
    parameter int RESET_YEAR = 2000,
    parameter int RESET_WDAY = 6,
    parameter bit GREGORIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [2:0]        load_wday,
    output logic [4:0]        num_day,
    output logic [3:0]        num_month,
    output logic [YEAR_W-1:0] num_year,
    output logic [2:0]        num_wday,
    output logic [4:0]        max_day,
    output logic              load_ack,
    output logic              load_err,
    output logic              new_month,
    output logic              new_year,
    output logic              year_wrap
);

    localparam logic [YEAR_W-1:0] Y_MIN   = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX   = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RESET = YEAR_W'(RESET_YEAR);
    localparam logic [2:0]        W_RESET = 3'(RESET_WDAY);

    logic [4:0] load_len;
    logic       load_valid;

    month_length_lut #(.YEAR_W(YEAR_W), .GREGORIAN(GREGORIAN)) u_cur_len (
        .month  (num_month),
        .year   (num_year),
        .length (max_day)
    );

    month_length_lut #(.YEAR_W(YEAR_W), .GREGORIAN(GREGORIAN)) u_load_len (
        .month  (load_month),
        .year   (load_year),
        .length (load_len)
    );

    always_comb begin
        load_valid = (load_month >= JAN) && (load_month <= DEC)
                  && (load_year >= Y_MIN) && (load_year <= Y_MAX)
                  && (load_wday <= SAT)
                  && (load_day != 5'd0) && (load_day <= load_len);
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_day   <= 5'd1;
            num_month <= JAN;
            num_year  <= Y_RESET;
            num_wday  <= W_RESET;
            load_ack  <= 1'b0;
            load_err  <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            year_wrap <= 1'b0;
        end else begin
            load_ack  <= 1'b0;
            load_err  <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            year_wrap <= 1'b0;
            // A load, accepted or not, swallows a coincident tick.
            if (load) begin
                if (load_valid) begin
                    num_day   <= load_day;
                    num_month <= load_month;
                    num_year  <= load_year;
                    num_wday  <= load_wday;
                    load_ack  <= 1'b1;
                end else begin
                    load_err  <= 1'b1;
                end
            end else if (day_tick) begin
                num_wday <= (num_wday == SAT) ? SUN : num_wday + 3'd1;
                if (num_day < max_day) begin
                    num_day <= num_day + 5'd1;
                end else begin
                    num_day   <= 5'd1;
                    new_month <= 1'b1;
                    if (num_month == DEC) begin
                        num_month <= JAN;
                        new_year  <= 1'b1;
                        if (num_year == Y_MAX) begin
                            num_year  <= Y_MIN;
                            year_wrap <= 1'b1;
                        end else begin
                            num_year <= num_year + YEAR_W'(1);
                        end
                    end else begin
                        num_month <= num_month + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench: a Gregorian and a legacy-rule counter share one stimulus
// stream; an independent date model predicts both.
module tb_calendar_date_counter;

    typedef struct {
        logic [4:0]  day;
        logic [3:0]  month;
        logic [15:0] year;
        logic [2:0]  wday;
        logic        ack;
        logic        err;
        logic        nm;
        logic        ny;
        logic        wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        day_tick;
    logic        load;
    logic [4:0]  load_day;
    logic [3:0]  load_month;
    logic [15:0] load_year;
    logic [2:0]  load_wday;

    logic [4:0]  g_day, l_day, g_max, l_max;
    logic [3:0]  g_month, l_month;
    logic [15:0] g_year, l_year;
    logic [2:0]  g_wday, l_wday;
    logic        g_ack, l_ack, g_err, l_err, g_nm, l_nm, g_ny, l_ny, g_wrap, l_wrap;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t st_g, st_l;
    exp_t q_g[$];
    exp_t q_l[$];

    always #5 clk = ~clk;

    calendar_date_counter #(.GREGORIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year), .load_wday(load_wday),
        .num_day(g_day), .num_month(g_month), .num_year(g_year), .num_wday(g_wday),
        .max_day(g_max), .load_ack(g_ack), .load_err(g_err),
        .new_month(g_nm), .new_year(g_ny), .year_wrap(g_wrap)
    );

    calendar_date_counter #(.GREGORIAN(1'b0)) dut_legacy (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year), .load_wday(load_wday),
        .num_day(l_day), .num_month(l_month), .num_year(l_year), .num_wday(l_wday),
        .max_day(l_max), .load_ack(l_ack), .load_err(l_err),
        .new_month(l_nm), .new_year(l_ny), .year_wrap(l_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit tb_leap(input logic [15:0] y, input bit greg);
        int unsigned yy;
        yy = 32'(y);
        if (!greg)            return (yy % 4) == 0;
        if ((yy % 400) == 0)  return 1'b1;
        if ((yy % 100) == 0)  return 1'b0;
        return (yy % 4) == 0;
    endfunction

    function automatic logic [4:0] tb_len(input logic [3:0] m, input logic [15:0] y, input bit greg);
        if (m == 4'd0 || m > 4'd12)                          return 5'd0;
        if (m == 4'd2)                                       return tb_leap(y, greg) ? 5'd29 : 5'd28;
        if (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) return 5'd30;
        return 5'd31;
    endfunction

    function automatic exp_t reset_state();
        exp_t r;
        r.day = 5'd1; r.month = 4'd1; r.year = 16'd2000; r.wday = 3'd6;
        r.ack = 1'b0; r.err = 1'b0; r.nm = 1'b0; r.ny = 1'b0; r.wrap = 1'b0;
        return r;
    endfunction

    function automatic exp_t model_step(input exp_t s, input bit greg, input logic tick, input logic ld,
                                        input logic [4:0] d, input logic [3:0] m,
                                        input logic [15:0] y, input logic [2:0] w);
        exp_t n;
        n = s;
        n.ack = 1'b0; n.err = 1'b0; n.nm = 1'b0; n.ny = 1'b0; n.wrap = 1'b0;
        if (ld) begin
            if (m >= 4'd1 && m <= 4'd12 && y >= 16'd2000 && y <= 16'd2199 && w <= 3'd6 &&
                d >= 5'd1 && d <= tb_len(m, y, greg)) begin
                n.day = d; n.month = m; n.year = y; n.wday = w; n.ack = 1'b1;
            end else begin
                n.err = 1'b1;
            end
        end else if (tick) begin
            n.wday = (s.wday == 3'd6) ? 3'd0 : s.wday + 3'd1;
            if (s.day < tb_len(s.month, s.year, greg)) begin
                n.day = s.day + 5'd1;
            end else begin
                n.day = 5'd1;
                n.nm  = 1'b1;
                if (s.month == 4'd12) begin
                    n.month = 4'd1;
                    n.ny    = 1'b1;
                    if (s.year == 16'd2199) begin
                        n.year = 16'd2000;
                        n.wrap = 1'b1;
                    end else begin
                        n.year = s.year + 16'd1;
                    end
                end else begin
                    n.month = s.month + 4'd1;
                end
            end
        end
        return n;
    endfunction

    task automatic check_dut(input exp_t e, input bit greg);
        string p;
        p = greg ? "greg." : "legacy.";
        check({p, "day"},       greg ? 32'(g_day)   : 32'(l_day),   32'(e.day));
        check({p, "month"},     greg ? 32'(g_month) : 32'(l_month), 32'(e.month));
        check({p, "year"},      greg ? 32'(g_year)  : 32'(l_year),  32'(e.year));
        check({p, "wday"},      greg ? 32'(g_wday)  : 32'(l_wday),  32'(e.wday));
        check({p, "max_day"},   greg ? 32'(g_max)   : 32'(l_max),   32'(tb_len(e.month, e.year, greg)));
        check({p, "load_ack"},  greg ? 32'(g_ack)   : 32'(l_ack),   32'(e.ack));
        check({p, "load_err"},  greg ? 32'(g_err)   : 32'(l_err),   32'(e.err));
        check({p, "new_month"}, greg ? 32'(g_nm)    : 32'(l_nm),    32'(e.nm));
        check({p, "new_year"},  greg ? 32'(g_ny)    : 32'(l_ny),    32'(e.ny));
        check({p, "year_wrap"}, greg ? 32'(g_wrap)  : 32'(l_wrap),  32'(e.wrap));
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (q_g.size() == 0 || q_l.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q_g.pop_front();
            check_dut(e, 1'b1);
            e = q_l.pop_front();
            check_dut(e, 1'b0);
        end
    endtask

    // One clock of stimulus: predict, push, let the edge happen, pop and compare.
    task automatic step(input logic tick, input logic ld, input logic [4:0] d,
                        input logic [3:0] m, input logic [15:0] y, input logic [2:0] w);
        day_tick = tick; load = ld;
        load_day = d; load_month = m; load_year = y; load_wday = w;
        st_g = model_step(st_g, 1'b1, tick, ld, d, m, y, w);
        st_l = model_step(st_l, 1'b0, tick, ld, d, m, y, w);
        q_g.push_back(st_g);
        q_l.push_back(st_l);
        @(posedge clk);
        #1;
        compare_outputs();
        day_tick = 1'b0; load = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 5'd0, 4'd0, 16'd0, 3'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 4'd0, 16'd0, 3'd0);
    endtask

    task automatic do_load(input logic [15:0] y, input logic [3:0] m, input logic [4:0] d, input logic [2:0] w);
        step(1'b0, 1'b1, d, m, y, w);
    endtask

    initial begin
        rst_n = 1'b0; day_tick = 1'b0; load = 1'b0;
        load_day = 5'd0; load_month = 4'd0; load_year = 16'd0; load_wday = 3'd0;
        st_g = reset_state();
        st_l = reset_state();
        #12;
        check_dut(st_g, 1'b1);
        check_dut(st_l, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle();
        // Leap February in 2000, then month rollover.
        do_load(16'd2000, 4'd2, 5'd28, 3'd1);
        tick();
        tick();
        // Century rule: 2100 is leap only under the legacy rule.
        do_load(16'd2100, 4'd2, 5'd28, 3'd0);
        tick();
        do_load(16'd2100, 4'd2, 5'd29, 3'd1);
        // Upper-bound wrap; pulses must fall after one cycle.
        do_load(16'd2199, 4'd12, 5'd31, 3'd6);
        tick();
        idle();
        // Rejected loads leave state alone.
        do_load(16'd2023, 4'd2, 5'd28, 3'd2);
        do_load(16'd2023, 4'd2, 5'd29, 3'd3);
        do_load(16'd2023, 4'd13, 5'd1, 3'd3);
        do_load(16'd1999, 4'd1, 5'd1, 3'd3);
        do_load(16'd2200, 4'd1, 5'd1, 3'd3);
        do_load(16'd2023, 4'd3, 5'd0, 3'd3);
        do_load(16'd2023, 4'd3, 5'd1, 3'd7);
        do_load(16'd2023, 4'd4, 5'd31, 3'd3);
        step(1'b1, 1'b1, 5'd30, 4'd2, 16'd2023, 3'd3);
        // Load beats a coincident tick.
        do_load(16'd2024, 4'd11, 5'd29, 3'd5);
        step(1'b1, 1'b1, 5'd30, 4'd11, 16'd2024, 3'd6);
        tick();
        do_load(16'd2024, 4'd2, 5'd29, 3'd4);
        do_load(16'd2000, 4'd12, 5'd31, 3'd0);
        tick();

        // Asynchronous reset while rollover pulses are high.
        do_load(16'd2199, 4'd12, 5'd31, 3'd6);
        tick();
        #1;
        rst_n = 1'b0;
        st_g = reset_state();
        st_l = reset_state();
        #1;
        check_dut(st_g, 1'b1);
        check_dut(st_l, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15, 0) == 0) begin
                step($urandom_range(1, 0) == 1, 1'b1,
                     5'($urandom_range(31, 0)), 4'($urandom_range(13, 0)),
                     16'($urandom_range(2201, 1998)), 3'($urandom_range(7, 0)));
            end else if ($urandom_range(63, 0) == 0) begin
                do_load(16'($urandom_range(2199, 2195)), 4'd12, 5'd25, 3'($urandom_range(6, 0)));
            end else begin
                step($urandom_range(3, 0) != 0, 1'b0, 5'd0, 4'd0, 16'd0, 3'd0);
            end
        end

        check("scoreboard_drained", 32'(q_g.size() + q_l.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
Sequential calendar core for the century clock. It advances day, month, year and weekday on each midnight tick from the time-of-day counter, and applies the full Gregorian leap rule (years divisible by 100 are not leap unless divisible by 400). It accepts validated date loads from the setting logic and emits rollover pulses for the display and alarm blocks. It supersedes the fixed-width, %4-only month-length lookup.

Parameters:
YEAR_W, 16, width of year registers and ports
YEAR_MIN, 2000, lowest representable year; wrap target
YEAR_MAX, 2199, highest representable year; the tick after YEAR_MAX-12-31 wraps to YEAR_MIN-01-01
RESET_YEAR, 2000, year loaded at reset; must satisfy YEAR_MIN <= RESET_YEAR <= YEAR_MAX
RESET_WDAY, 6, weekday loaded at reset (0=Sunday..6=Saturday); 6 matches 2000-01-01
GREGORIAN, 1, 1 = full Gregorian rule; 0 = legacy rule, leap iff year%4==0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
day_tick  in  1  one-cycle pulse at midnight rollover
load  in  1  one-cycle request to set the date
load_day  in  5  day to load, 1..31
load_month  in  4  month to load, 1..12
load_year  in  YEAR_W  year to load
load_wday  in  3  weekday to load, 0..6
num_day  out  5  current day of month
num_month  out  4  current month
num_year  out  YEAR_W  current year
num_wday  out  3  current weekday
max_day  out  5  length of the current month (combinational from the current state)
load_ack  out  1  one-cycle pulse: the load was accepted
load_err  out  1  one-cycle pulse: the load was rejected
new_month  out  1  one-cycle pulse: a tick crossed a month boundary
new_year  out  1  one-cycle pulse: a tick crossed a year boundary
year_wrap  out  1  one-cycle pulse: the year wrapped from YEAR_MAX to YEAR_MIN

Behaviour:
- Reset (async assert, sync release): day=1, month=1, year=RESET_YEAR, wday=RESET_WDAY. All pulse outputs are 0.
- All date outputs and pulses are registered. State updates on the clk edge where the event is sampled; pulses assert the following cycle for exactly 1 cycle.
- Leap year when GREGORIAN=1: (y%4==0 && y%100!=0) || y%400==0. Month lengths are 31/28-29/31/30/31/30/31/31/30/31/30/31. Month 11 is 30 days; month 12 is 31.
- Tick when day<max_day: day+1.
- Tick when day==max_day and month<12: day=1, month+1, new_month.
- Tick when day==max_day and month==12: day=1, month=1, new_month and new_year. The year becomes year+1, or YEAR_MIN plus year_wrap if year==YEAR_MAX.
- Every tick: wday=(wday==6)?0:wday+1.
- Load validation happens in the same cycle the load is sampled. A load is valid iff all of the following hold: 1<=load_month<=12; YEAR_MIN<=load_year<=YEAR_MAX; load_wday<=6; 1<=load_day<=length(load_month,load_year). Weekday consistency is not checked.
- Valid load: state takes the load values; load_ack pulses.
- Invalid load: state is unchanged; load_err pulses; no rollover pulses.
- load and day_tick in the same cycle: load has priority and the tick is dropped. This holds even when the load is rejected.
- Year arithmetic uses YEAR_W-bit unsigned values. The %100 and %400 checks must be correct for every value up to 2^YEAR_W-1.
- Reset asserted mid-operation forces reset values immediately and clears any pulse in flight.
- State is reachable only via reset, tick or validated load, so day<=max_day always holds.

Decomposition:
- Shared package calendar_pkg holds:
  - month constants JAN..DEC;
  - length constants (31, 30, FEB_NORMAL=28, FEB_LEAP=29);
  - weekday constants SUN..SAT;
  - function is_leap(year, gregorian).
- Sub-module month_length_lut: purely combinational (month, year) -> length, parametrised by YEAR_W and GREGORIAN.
- Instantiate month_length_lut twice: once on the current state to drive max_day, once on the load inputs for validation.

Test Plan:
- Reset release -> 2000-01-01, wday=6; max_day=31; all pulses 0.
- Load 2000-02-28 wday=1, then tick -> 2000-02-29, wday=2; tick -> 2000-03-01, wday=3, new_month=1, new_year=0.
- Load 2100-02-28, then tick -> 2100-03-01 (2100 not leap). With GREGORIAN=0 the same stimulus -> 2100-02-29.
- Load 2199-12-31 wday=6, then tick -> 2000-01-01, wday=0; new_month, new_year and year_wrap each high for exactly 1 cycle.
- Load 2023-02-29 -> load_err=1, load_ack=0, state unchanged. Load 2023-13-01 -> load_err=1. Load 1999-01-01 -> load_err=1.
- load=1 (2024-11-30) and day_tick=1 in the same cycle from 2024-11-29 -> state 2024-11-30, load_ack=1, no new_month. Next tick -> 2024-12-01, new_month=1.
